// File: rtl/frv_asi_ctrl_pkg.sv
// frv_asi_ctrl_pkg
// Shared definitions for the ASI sequencing controller:
// FSM state encodings, default widths, and the ASI micro-op encodings
// used by the execute stage when it talks to frv_asi.

package frv_asi_ctrl_pkg;

    // Default datapath and micro-op widths
    localparam int XLEN_DEF           = 32;
    localparam int UOPW_DEF           = 7;
    localparam int TIMEOUT_CYCLES_DEF = 15;
    localparam int WDOG_W             = 4;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_RESP  = 2'd2,
        ST_FLUSH = 2'd3
    } asi_state_e;

    // ASI micro-op encodings
    localparam logic [6:0] UOP_AES_SUB     = 7'h10;
    localparam logic [6:0] UOP_AES_MIX     = 7'h11;
    localparam logic [6:0] UOP_SHA256_S0   = 7'h20;
    localparam logic [6:0] UOP_SHA256_S1   = 7'h21;
    localparam logic [6:0] UOP_SHA256_SUM0 = 7'h22;
    localparam logic [6:0] UOP_SHA256_SUM1 = 7'h23;
    localparam logic [6:0] UOP_SHA512_SUM0 = 7'h28;
    localparam logic [6:0] UOP_SHA3_XY     = 7'h30;

endpackage

// File: rtl/frv_asi_ctrl_wdog.sv
// frv_asi_ctrl_wdog
// EXEC watchdog. Counts EXEC cycles in which frv_asi has not yet
// answered; 'expired' fires combinationally in the cycle whose count
// reaches LIMIT, so the controller can leave EXEC on that same edge.
// A ready in the limit cycle masks expiry (normal completion wins).
// Only instantiated when FRV_ASI_CTRL_TIMEOUT_EN is defined.

module frv_asi_ctrl_wdog
    import frv_asi_ctrl_pkg::*;
#(
    parameter int LIMIT = TIMEOUT_CYCLES_DEF
) (
    input  logic g_clk,
    input  logic g_resetn,
    input  logic enable,
    input  logic clear,
    input  logic ready,
    output logic expired
);

    localparam logic [WDOG_W-1:0] LAST_C = WDOG_W'(LIMIT - 1);
    localparam logic [WDOG_W-1:0] MAX_C  = {WDOG_W{1'b1}};

    logic [WDOG_W-1:0] cnt_r;

    // Count waiting EXEC cycles; restart whenever a new operation enters EXEC
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            cnt_r <= {WDOG_W{1'b0}};
        end else if (clear) begin
            cnt_r <= {WDOG_W{1'b0}};
        end else if (enable && !ready && (cnt_r != MAX_C)) begin
            cnt_r <= cnt_r + {{(WDOG_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired = enable & ~ready & (cnt_r == LAST_C);

endmodule

// File: rtl/frv_asi_ctrl.sv
// frv_asi_ctrl
// Sequencing controller in front of frv_asi. Accepts one ASI operation at
// a time, holds its operands stable while frv_asi runs, captures the result
// into a response register, and interleaves AES sub/mix state flushes.
// Operand and result registers are scrubbed to zero on every return to
// IDLE so no secret material lingers on the frv_asi inputs.
//
// Optional feature macro: FRV_ASI_CTRL_TIMEOUT_EN
//   defined   -> EXEC watchdog; a timed-out op responds with result 0, error 1
//   undefined -> EXEC waits for asi_ready or pipe_kill; rsp_error is 0

module frv_asi_ctrl
    import frv_asi_ctrl_pkg::*;
#(
    parameter int XLEN           = XLEN_DEF,
    parameter int UOPW           = UOPW_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic            g_clk,
    input  logic            g_resetn,

    input  logic            req_valid,
    output logic            req_ready,
    input  logic [UOPW-1:0] req_uop,
    input  logic [XLEN-1:0] req_rs1,
    input  logic [XLEN-1:0] req_rs2,
    input  logic [1:0]      req_shamt,

    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_result,
    output logic            rsp_error,

    input  logic            pipe_kill,

    input  logic            flush_req,
    input  logic [1:0]      flush_sel,
    input  logic [XLEN-1:0] flush_data,
    output logic            flush_ack,

    output logic            asi_valid,
    input  logic            asi_ready,
    output logic [UOPW-1:0] asi_uop,
    output logic [XLEN-1:0] asi_rs1,
    output logic [XLEN-1:0] asi_rs2,
    output logic [1:0]      asi_shamt,
    input  logic [XLEN-1:0] asi_result,

    output logic            asi_flush_aessub,
    output logic            asi_flush_aesmix,
    output logic [XLEN-1:0] asi_flush_data,

    output logic            busy
);

    asi_state_e      state_r;
    asi_state_e      state_nxt_s;

    logic            accept_s;
    logic            complete_s;
    logic            timeout_s;
    logic            wdog_expired_s;

    logic [UOPW-1:0] uop_r;
    logic [XLEN-1:0] rs1_r;
    logic [XLEN-1:0] rs2_r;
    logic [1:0]      shamt_r;
    logic [XLEN-1:0] result_r;

    logic            asi_valid_r;
    logic            rsp_valid_r;
    logic            busy_r;
    logic            flush_ack_r;
    logic            flush_sub_r;
    logic            flush_mix_r;
    logic [XLEN-1:0] flush_data_r;

    // Next-state decode; flush beats a request in IDLE, kill beats completion in EXEC
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        complete_s  = 1'b0;
        timeout_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (flush_req) begin
                    state_nxt_s = ST_FLUSH;
                end else if (req_valid) begin
                    state_nxt_s = ST_EXEC;
                    accept_s    = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (pipe_kill) begin
                    state_nxt_s = ST_IDLE;
                end else if (asi_ready) begin
                    state_nxt_s = ST_RESP;
                    complete_s  = 1'b1;
                end else if (wdog_expired_s) begin
                    state_nxt_s = ST_RESP;
                    timeout_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_EXEC;
                end
            end
            ST_RESP: begin
                if (pipe_kill || rsp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            ST_FLUSH: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Registered status outputs, decoded from the state being entered
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            asi_valid_r <= 1'b0;
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            flush_ack_r <= 1'b0;
        end else begin
            asi_valid_r <= (state_nxt_s == ST_EXEC);
            rsp_valid_r <= (state_nxt_s == ST_RESP);
            busy_r      <= (state_nxt_s != ST_IDLE);
            flush_ack_r <= (state_nxt_s == ST_FLUSH);
        end
    end

    // Flush strobes and data: latched from IDLE for the single FLUSH cycle, zero otherwise
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            flush_sub_r  <= 1'b0;
            flush_mix_r  <= 1'b0;
            flush_data_r <= {XLEN{1'b0}};
        end else if (state_nxt_s == ST_FLUSH) begin
            flush_sub_r  <= flush_sel[0];
            flush_mix_r  <= flush_sel[1];
            flush_data_r <= flush_data;
        end else begin
            flush_sub_r  <= 1'b0;
            flush_mix_r  <= 1'b0;
            flush_data_r <= {XLEN{1'b0}};
        end
    end

    // Operand register: capture on accept, hold through EXEC/RESP, scrub on return to IDLE
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            uop_r   <= {UOPW{1'b0}};
            rs1_r   <= {XLEN{1'b0}};
            rs2_r   <= {XLEN{1'b0}};
            shamt_r <= 2'b00;
        end else if (accept_s) begin
            uop_r   <= req_uop;
            rs1_r   <= req_rs1;
            rs2_r   <= req_rs2;
            shamt_r <= req_shamt;
        end else if (state_nxt_s == ST_IDLE) begin
            uop_r   <= {UOPW{1'b0}};
            rs1_r   <= {XLEN{1'b0}};
            rs2_r   <= {XLEN{1'b0}};
            shamt_r <= 2'b00;
        end else begin
            uop_r   <= uop_r;
            rs1_r   <= rs1_r;
            rs2_r   <= rs2_r;
            shamt_r <= shamt_r;
        end
    end

    // Result register: capture on completion, zero on timeout or return to IDLE
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            result_r <= {XLEN{1'b0}};
        end else if (complete_s) begin
            result_r <= asi_result;
        end else if (timeout_s || (state_nxt_s == ST_IDLE)) begin
            result_r <= {XLEN{1'b0}};
        end else begin
            result_r <= result_r;
        end
    end

`ifdef FRV_ASI_CTRL_TIMEOUT_EN
    logic error_r;

    frv_asi_ctrl_wdog #(
        .LIMIT    (TIMEOUT_CYCLES)
    ) u_wdog (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .enable   (state_r == ST_EXEC),
        .clear    (accept_s),
        .ready    (asi_ready),
        .expired  (wdog_expired_s)
    );

    // Error flag: set only by a watchdog expiry, cleared by completion or return to IDLE
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            error_r <= 1'b0;
        end else if (timeout_s) begin
            error_r <= 1'b1;
        end else if (complete_s || (state_nxt_s == ST_IDLE)) begin
            error_r <= 1'b0;
        end else begin
            error_r <= error_r;
        end
    end

    assign rsp_error = error_r;
`else
    assign wdog_expired_s = 1'b0;
    assign rsp_error      = 1'b0;
`endif

    // req_ready is combinational so a request can be taken in the first IDLE cycle
    assign req_ready        = g_resetn & (state_r == ST_IDLE) & ~flush_req;

    assign rsp_valid        = rsp_valid_r;
    assign rsp_result       = result_r;
    assign flush_ack        = flush_ack_r;
    assign asi_valid        = asi_valid_r;
    assign asi_uop          = uop_r;
    assign asi_rs1          = rs1_r;
    assign asi_rs2          = rs2_r;
    assign asi_shamt        = shamt_r;
    assign asi_flush_aessub = flush_sub_r;
    assign asi_flush_aesmix = flush_mix_r;
    assign asi_flush_data   = flush_data_r;
    assign busy             = busy_r;

endmodule

// File: tb/tb_frv_asi_ctrl.sv
// tb_frv_asi_ctrl
// Directed bench for frv_asi_ctrl. A behavioural frv_asi stub computes
// asi_result from the operands the controller presents; the expected
// result of each request is computed from the request fields and queued
// when the request is driven, then popped when the response appears.
// Inputs change and outputs are sampled on the falling clock edge.

module tb_frv_asi_ctrl;
    import frv_asi_ctrl_pkg::*;

    logic        g_clk     = 1'b0;
    logic        g_resetn  = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [6:0]  req_uop   = 7'd0;
    logic [31:0] req_rs1   = 32'd0;
    logic [31:0] req_rs2   = 32'd0;
    logic [1:0]  req_shamt = 2'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_result;
    logic        rsp_error;
    logic        pipe_kill = 1'b0;
    logic        flush_req = 1'b0;
    logic [1:0]  flush_sel = 2'd0;
    logic [31:0] flush_data = 32'd0;
    logic        flush_ack;
    logic        asi_valid;
    logic        asi_ready = 1'b0;
    logic [6:0]  asi_uop;
    logic [31:0] asi_rs1;
    logic [31:0] asi_rs2;
    logic [1:0]  asi_shamt;
    logic [31:0] asi_result;
    logic        asi_flush_aessub;
    logic        asi_flush_aesmix;
    logic [31:0] asi_flush_data;
    logic        busy;

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [31:0] exp_q[$];
    logic [31:0] held;

    frv_asi_ctrl dut (
        .g_clk            (g_clk),
        .g_resetn         (g_resetn),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_uop          (req_uop),
        .req_rs1          (req_rs1),
        .req_rs2          (req_rs2),
        .req_shamt        (req_shamt),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_result       (rsp_result),
        .rsp_error        (rsp_error),
        .pipe_kill        (pipe_kill),
        .flush_req        (flush_req),
        .flush_sel        (flush_sel),
        .flush_data       (flush_data),
        .flush_ack        (flush_ack),
        .asi_valid        (asi_valid),
        .asi_ready        (asi_ready),
        .asi_uop          (asi_uop),
        .asi_rs1          (asi_rs1),
        .asi_rs2          (asi_rs2),
        .asi_shamt        (asi_shamt),
        .asi_result       (asi_result),
        .asi_flush_aessub (asi_flush_aessub),
        .asi_flush_aesmix (asi_flush_aesmix),
        .asi_flush_data   (asi_flush_data),
        .busy             (busy)
    );

    always #5 g_clk = ~g_clk;

    // Behavioural stand-in for the frv_asi datapath
    function automatic logic [31:0] asi_model(input logic [6:0] uop, input logic [31:0] rs1,
                                              input logic [31:0] rs2, input logic [1:0] shamt);
        if (uop == UOP_SHA256_S0)
            return {rs1[1:0], rs1[31:2]} ^ {rs1[12:0], rs1[31:13]} ^ {rs1[21:0], rs1[31:22]};
        else
            return (rs1 ^ (rs2 << shamt)) + {25'd0, uop};
    endfunction

    assign asi_result = asi_model(asi_uop, asi_rs1, asi_rs2, asi_shamt);

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Compare rsp_result against the oldest queued expectation
    task automatic pop_check(input string tag, output logic [31:0] exp);
        exp = 32'd0;
        if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $error("FAIL %s: observed response %h expected no response (queue empty)", tag, rsp_result);
        end else begin
            exp = exp_q.pop_front();
            chk32(tag, rsp_result, exp);
        end
    endtask

    // Present a request for one cycle, then scramble the request fields
    task automatic send_req(input logic [6:0] uop, input logic [31:0] rs1, input logic [31:0] rs2,
                            input logic [1:0] shamt, input bit push);
        req_valid = 1'b1;
        req_uop   = uop;
        req_rs1   = rs1;
        req_rs2   = rs2;
        req_shamt = shamt;
        chk1("req_ready_at_send", req_ready, 1'b1);
        if (push) exp_q.push_back(asi_model(uop, rs1, rs2, shamt));
        @(negedge g_clk);
        req_valid = 1'b0;
        req_uop   = 7'h7F;
        req_rs1   = 32'hFFFF_FFFF;
        req_rs2   = 32'hFFFF_FFFF;
        req_shamt = 2'd3;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        // ---------------- reset state ----------------
        #3;
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_asi_valid", asi_valid, 1'b0);
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chk1("rst_flush_ack", flush_ack, 1'b0);
        chk1("rst_aessub", asi_flush_aessub, 1'b0);
        chk1("rst_aesmix", asi_flush_aesmix, 1'b0);
        chk32("rst_flush_data", asi_flush_data, 32'd0);
        chk32("rst_asi_rs1", asi_rs1, 32'd0);
        chk32("rst_asi_uop", 32'(asi_uop), 32'd0);
        chk32("rst_rsp_result", rsp_result, 32'd0);
        chk1("rst_rsp_error", rsp_error, 1'b0);
        chk1("rst_req_ready", req_ready, 1'b0);
        @(negedge g_clk);
        g_resetn = 1'b1;
        #1 chk1("post_rst_req_ready", req_ready, 1'b1);

        // ---------------- single-cycle SHA256_S0 ----------------
        @(negedge g_clk);
        asi_ready = 1'b1;
        send_req(UOP_SHA256_S0, 32'h6A09E667, 32'h0, 2'd0, 1'b1);
        chk1("s1_asi_valid", asi_valid, 1'b1);
        chk32("s1_asi_rs1", asi_rs1, 32'h6A09E667);
        chk32("s1_asi_uop", 32'(asi_uop), 32'(UOP_SHA256_S0));
        chk1("s1_rsp_valid_early", rsp_valid, 1'b0);
        chk1("s1_busy", busy, 1'b1);
        chk1("s1_req_ready_exec", req_ready, 1'b0);
        @(negedge g_clk);
        chk1("s1_rsp_valid", rsp_valid, 1'b1);
        chk1("s1_rsp_error", rsp_error, 1'b0);
        chk1("s1_asi_valid_resp", asi_valid, 1'b0);
        pop_check("s1_result", held);
        rsp_ready = 1'b1;
        @(negedge g_clk);
        rsp_ready = 1'b0;
        chk1("s1_rsp_valid_done", rsp_valid, 1'b0);
        chk32("s1_scrub_rs1", asi_rs1, 32'd0);
        chk32("s1_scrub_uop", 32'(asi_uop), 32'd0);
        chk32("s1_scrub_result", rsp_result, 32'd0);
        chk1("s1_idle", busy, 1'b0);

        // ---------------- multi-cycle AES sub ----------------
        asi_ready = 1'b0;
        send_req(UOP_AES_SUB, 32'h00112233, 32'h44556677, 2'd1, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            chk1("mc_asi_valid", asi_valid, 1'b1);
            chk32("mc_rs1_stable", asi_rs1, 32'h00112233);
            chk32("mc_rs2_stable", asi_rs2, 32'h44556677);
            chk1("mc_no_rsp", rsp_valid, 1'b0);
            if (i == 4) asi_ready = 1'b1;
            @(negedge g_clk);
        end
        asi_ready = 1'b0;
        chk1("mc_rsp_valid", rsp_valid, 1'b1);
        pop_check("mc_result", held);
        for (int i = 0; i < 2; i++) begin
            @(negedge g_clk);
            chk1("mc_rsp_held", rsp_valid, 1'b1);
            chk32("mc_result_held", rsp_result, held);
        end
        rsp_ready = 1'b1;
        @(negedge g_clk);
        rsp_ready = 1'b0;
        chk1("mc_idle", busy, 1'b0);
        chk1("mc_req_ready", req_ready, 1'b1);

        // ---------------- flush and request together ----------------
        asi_ready  = 1'b1;
        flush_req  = 1'b1;
        flush_sel  = 2'b11;
        flush_data = 32'hDEADBEEF;
        req_valid  = 1'b1;
        req_uop    = UOP_SHA512_SUM0;
        req_rs1    = 32'hCAFEF00D;
        req_rs2    = 32'h12345678;
        req_shamt  = 2'd2;
        #1 chk1("fl_req_ready_blocked", req_ready, 1'b0);
        @(negedge g_clk);
        chk1("fl_ack", flush_ack, 1'b1);
        chk1("fl_aessub", asi_flush_aessub, 1'b1);
        chk1("fl_aesmix", asi_flush_aesmix, 1'b1);
        chk32("fl_data", asi_flush_data, 32'hDEADBEEF);
        chk1("fl_no_exec", asi_valid, 1'b0);
        flush_req  = 1'b0;
        flush_data = 32'd0;
        exp_q.push_back(asi_model(UOP_SHA512_SUM0, 32'hCAFEF00D, 32'h12345678, 2'd2));
        @(negedge g_clk);
        chk1("fl_ack_pulse", flush_ack, 1'b0);
        chk1("fl_strobe_off", asi_flush_aessub, 1'b0);
        chk32("fl_data_off", asi_flush_data, 32'd0);
        chk1("fl_back_idle", busy, 1'b0);
        chk1("fl_req_ready", req_ready, 1'b1);
        @(negedge g_clk);
        req_valid = 1'b0;
        chk1("fl_req_exec", asi_valid, 1'b1);
        chk32("fl_req_rs1", asi_rs1, 32'hCAFEF00D);
        @(negedge g_clk);
        chk1("fl_req_rsp", rsp_valid, 1'b1);
        pop_check("fl_req_result", held);
        rsp_ready = 1'b1;
        @(negedge g_clk);
        rsp_ready = 1'b0;

        // flush with no selection still acknowledges
        flush_req  = 1'b1;
        flush_sel  = 2'b00;
        flush_data = 32'h12345678;
        @(negedge g_clk);
        chk1("fl0_ack", flush_ack, 1'b1);
        chk1("fl0_aessub", asi_flush_aessub, 1'b0);
        chk1("fl0_aesmix", asi_flush_aesmix, 1'b0);
        flush_req = 1'b0;
        @(negedge g_clk);
        chk1("fl0_ack_off", flush_ack, 1'b0);
        chk1("fl0_idle", busy, 1'b0);

        // flush raised during EXEC waits for IDLE
        asi_ready = 1'b0;
        send_req(UOP_SHA3_XY, 32'h0BADF00D, 32'h00000F0F, 2'd3, 1'b1);
        flush_req  = 1'b1;
        flush_sel  = 2'b01;
        flush_data = 32'hA5A5A5A5;
        @(negedge g_clk);
        chk1("fd_no_ack_exec", flush_ack, 1'b0);
        chk1("fd_still_exec", asi_valid, 1'b1);
        asi_ready = 1'b1;
        @(negedge g_clk);
        asi_ready = 1'b0;
        chk1("fd_rsp_valid", rsp_valid, 1'b1);
        chk1("fd_no_ack_resp", flush_ack, 1'b0);
        pop_check("fd_result", held);
        rsp_ready = 1'b1;
        @(negedge g_clk);
        rsp_ready = 1'b0;
        chk1("fd_no_ack_idle", flush_ack, 1'b0);
        @(negedge g_clk);
        chk1("fd_ack", flush_ack, 1'b1);
        chk1("fd_aessub", asi_flush_aessub, 1'b1);
        chk1("fd_aesmix", asi_flush_aesmix, 1'b0);
        chk32("fd_data", asi_flush_data, 32'hA5A5A5A5);
        flush_req = 1'b0;
        @(negedge g_clk);
        chk1("fd_idle", busy, 1'b0);

        // ---------------- pipe_kill ----------------
        asi_ready = 1'b1;
        send_req(UOP_SHA256_S1, 32'h11111111, 32'h22222222, 2'd0, 1'b0);
        chk1("k1_exec", asi_valid, 1'b1);
        pipe_kill = 1'b1;
        @(negedge g_clk);
        pipe_kill = 1'b0;
        chk1("k1_no_rsp", rsp_valid, 1'b0);
        chk1("k1_asi_valid_off", asi_valid, 1'b0);
        chk1("k1_idle", busy, 1'b0);
        chk32("k1_scrub_rs1", asi_rs1, 32'd0);
        @(negedge g_clk);
        chk1("k1_still_no_rsp", rsp_valid, 1'b0);

        send_req(UOP_SHA256_SUM0, 32'h33333333, 32'h44444444, 2'd1, 1'b0);
        @(negedge g_clk);
        chk1("k2_rsp_valid", rsp_valid, 1'b1);
        pipe_kill = 1'b1;
        @(negedge g_clk);
        pipe_kill = 1'b0;
        chk1("k2_discard", rsp_valid, 1'b0);
        chk32("k2_scrub_result", rsp_result, 32'd0);
        chk1("k2_idle", busy, 1'b0);

        // kill in IDLE is ignored
        pipe_kill = 1'b1;
        send_req(UOP_SHA256_SUM1, 32'h55555555, 32'h66666666, 2'd2, 1'b1);
        pipe_kill = 1'b0;
        chk1("k3_exec", asi_valid, 1'b1);
        @(negedge g_clk);
        chk1("k3_rsp_valid", rsp_valid, 1'b1);
        pop_check("k3_result", held);
        rsp_ready = 1'b1;
        @(negedge g_clk);
        rsp_ready = 1'b0;

        // ---------------- watchdog ----------------
        asi_ready = 1'b0;
`ifdef FRV_ASI_CTRL_TIMEOUT_EN
        send_req(UOP_AES_MIX, 32'h77777777, 32'h88888888, 2'd0, 1'b0);
        for (int i = 1; i <= 15; i++) begin
            chk1("to_exec", asi_valid, 1'b1);
            chk1("to_no_rsp", rsp_valid, 1'b0);
            @(negedge g_clk);
        end
        chk1("to_rsp_valid", rsp_valid, 1'b1);
        chk1("to_rsp_error", rsp_error, 1'b1);
        chk32("to_result_zero", rsp_result, 32'd0);
        rsp_ready = 1'b1;
        @(negedge g_clk);
        rsp_ready = 1'b0;
        chk1("to_idle", busy, 1'b0);
        chk1("to_error_clr", rsp_error, 1'b0);

        // ready in the limit cycle completes normally
        send_req(UOP_AES_MIX, 32'h99999999, 32'h0000AAAA, 2'd1, 1'b1);
        for (int i = 1; i <= 15; i++) begin
            chk1("tl_no_rsp", rsp_valid, 1'b0);
            if (i == 15) asi_ready = 1'b1;
            @(negedge g_clk);
        end
        asi_ready = 1'b0;
        chk1("tl_rsp_valid", rsp_valid, 1'b1);
        chk1("tl_rsp_error", rsp_error, 1'b0);
        pop_check("tl_result", held);
        rsp_ready = 1'b1;
        @(negedge g_clk);
        rsp_ready = 1'b0;
`else
        send_req(UOP_AES_MIX, 32'h77777777, 32'h88888888, 2'd0, 1'b0);
        for (int i = 0; i < 100; i++) begin
            chk1("nt_busy", busy, 1'b1);
            chk1("nt_no_rsp", rsp_valid, 1'b0);
            @(negedge g_clk);
        end
        chk1("nt_no_error", rsp_error, 1'b0);
        pipe_kill = 1'b1;
        @(negedge g_clk);
        pipe_kill = 1'b0;
        chk1("nt_idle", busy, 1'b0);
        chk1("nt_no_rsp_after", rsp_valid, 1'b0);
`endif

        // ---------------- asynchronous reset mid-EXEC ----------------
        send_req(UOP_SHA256_S0, 32'hBBBBBBBB, 32'hCCCCCCCC, 2'd2, 1'b0);
        chk1("ar_exec", asi_valid, 1'b1);
        #2 g_resetn = 1'b0;
        #1;
        chk1("ar_asi_valid", asi_valid, 1'b0);
        chk1("ar_busy", busy, 1'b0);
        chk32("ar_rs1", asi_rs1, 32'd0);
        chk32("ar_uop", 32'(asi_uop), 32'd0);
        chk1("ar_req_ready", req_ready, 1'b0);
        chk1("ar_rsp_valid", rsp_valid, 1'b0);
        #1 g_resetn = 1'b1;
        @(negedge g_clk);
        chk1("ar_post_busy", busy, 1'b0);
        chk1("ar_post_rsp", rsp_valid, 1'b0);
        chk1("ar_post_req_ready", req_ready, 1'b1);

        // asynchronous reset mid-FLUSH
        flush_req  = 1'b1;
        flush_sel  = 2'b11;
        flush_data = 32'h0F0F0F0F;
        @(negedge g_clk);
        chk1("arf_ack", flush_ack, 1'b1);
        flush_req = 1'b0;
        #2 g_resetn = 1'b0;
        #1;
        chk1("arf_ack_off", flush_ack, 1'b0);
        chk1("arf_aessub_off", asi_flush_aessub, 1'b0);
        chk32("arf_data_off", asi_flush_data, 32'd0);
        #1 g_resetn = 1'b1;
        @(negedge g_clk);
        chk1("arf_idle", busy, 1'b0);
        chk1("arf_no_ack", flush_ack, 1'b0);

        // every queued expectation was matched by a response
        chk32("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/frv_asi_ctrl.md
# frv_asi_ctrl

Sequencing controller in front of `frv_asi`, the algorithm-specific-instruction datapath for AES, SHA2 and SHA3.
- Accepts one ASI operation at a time from the execute stage over a valid/ready handshake.
- Registers the operands and holds them stable while `frv_asi` runs (single- or multi-cycle).
- Captures the result into a response register.
- Schedules AES sub/mix state flushes requested by the CSR/context-restore path, interleaving them with operations.

## Interface
Parameters:
- `XLEN`, 32, datapath width.
- `UOPW`, 7, micro-op width (`OP+1` from `frv_common.vh`).
- `TIMEOUT_CYCLES`, 15, watchdog limit in EXEC (used only with `FRV_ASI_CTRL_TIMEOUT_EN`).

Ports:
- `g_clk` in 1: global clock.
- `g_resetn` in 1: reset, asynchronous, active-low.
- `req_valid` in 1, `req_ready` out 1: operation request handshake.
- `req_uop` in UOPW, `req_rs1` in XLEN, `req_rs2` in XLEN, `req_shamt` in 2: operation operands.
- `rsp_valid` out 1, `rsp_ready` in 1: response handshake.
- `rsp_result` out XLEN: operation result.
- `rsp_error` out 1: operation timed out.
- `pipe_kill` in 1: abort the in-flight operation or pending response.
- `flush_req` in 1: flush request (level; held until `flush_ack`).
- `flush_sel` in 2: bit0 flushes AES sub, bit1 flushes AES mix.
- `flush_data` in XLEN: data to flush into the submodules.
- `flush_ack` out 1: one-cycle flush-complete pulse.
- `asi_valid` out 1, `asi_ready` in 1: handshake to `frv_asi`.
- `asi_uop`, `asi_rs1`, `asi_rs2`, `asi_shamt` out: operands to `frv_asi`.
- `asi_result` in XLEN: result from `frv_asi`.
- `asi_flush_aessub` out 1, `asi_flush_aesmix` out 1, `asi_flush_data` out XLEN: flush controls to `frv_asi`.
- `busy` out 1: state != IDLE.

## Operation
States: IDLE, EXEC, RESP, FLUSH (encodings in `frv_common.vh`).

IDLE:
- `req_ready = !flush_req`.
- `flush_req` takes priority over `req_valid` when both are asserted in the same cycle.
- On `flush_req`: latch `flush_sel` and `flush_data`, go to FLUSH.
- Else on `req_valid`: latch uop, rs1, rs2 and shamt into the operand register, go to EXEC.

EXEC:
- `asi_valid = 1`; `asi_*` operands come from the operand register and are stable throughout.
- On `asi_ready`: capture `asi_result` into `rsp_result`, set `rsp_error = 0`, go to RESP.

RESP:
- `rsp_valid = 1`; `rsp_result` is held.
- On `rsp_ready`: go to IDLE and zero the operand and result registers, so `frv_asi` inputs return to all-zero with no stale secret data.

FLUSH (one cycle):
- Drive `asi_flush_aessub = sel[0]`, `asi_flush_aesmix = sel[1]`, `asi_flush_data` = latched data.
- Pulse `flush_ack`, return to IDLE.
- If `flush_sel == 0`, still ack with no flush strobes.

`flush_req` raised during EXEC or RESP waits until IDLE; it is never dropped.

`pipe_kill`:
- In EXEC: deassert `asi_valid` next cycle, go to IDLE, no response. A kill in the same cycle as `asi_ready` wins.
- In RESP: discard the response, go to IDLE.
- In IDLE or FLUSH: ignored.

Outside EXEC: `asi_valid = 0`. Outside FLUSH: all `asi_flush_*` strobes are 0.

## Timing
- Reset: state IDLE; every output 0, including all `asi_*` outputs, `rsp_*` outputs, `flush_ack` and `busy`. `req_ready` reads 1 combinationally once `g_resetn` is high and `flush_req` is low.
- Reset asserted mid-EXEC or mid-FLUSH: immediate return to IDLE; no response, no ack.
- Request accepted at cycle N:
  - `asi_valid` high in N+1.
  - For a single-cycle op (`asi_ready` in N+1), `rsp_valid` is high in N+2.
  - For a k-cycle op, `rsp_valid` is high in N+1+k.
- Throughput: one op per 3 cycles minimum (IDLE→EXEC→RESP). No back-to-back accept while RESP is pending.
- Flush: `flush_req` sampled in IDLE at cycle M gives strobes and `flush_ack` in M+1 and IDLE in M+2. The requester must drop `flush_req` on `flush_ack`.

## Configuration
Macro `FRV_ASI_CTRL_TIMEOUT_EN`.

Defined:
- 4-bit counter, cleared on entering EXEC, increments each EXEC cycle without `asi_ready`.
- When the count reaches `TIMEOUT_CYCLES`: go to RESP with `rsp_result = 0`, `rsp_error = 1`.
- `asi_ready` in the same cycle as the limit is a normal completion.

Undefined:
- No counter; `rsp_error` is tied to 0.
- EXEC waits indefinitely for `asi_ready` or `pipe_kill`.

## Structure
- State encodings, `UOPW`, and the ASI uop constants live in the shared `frv_common.vh`.
- The watchdog is the one natural sub-module, `frv_asi_ctrl_wdog` (inputs: enable, clear, ready; output: expired), instantiated only under the macro.
- FSM, operand register and response register stay in `frv_asi_ctrl`.

## Test plan
- Single-cycle op: reset, then `req_valid` with SHA256_S0 and rs1 = 0x6A09E667; `asi_ready` tied 1 in EXEC. Expect `rsp_valid` at N+2 with `rsp_result` = model of `asi_result`, `rsp_error = 0`; operands read 0 after `rsp_ready`.
- Multi-cycle AES sub: `asi_ready` delayed 4 cycles. Expect `asi_rs1`/`asi_rs2` stable at 0x00112233/0x44556677 for all 4 EXEC cycles and `rsp_valid` at N+5; `rsp_ready` held low 3 cycles keeps the result stable.
- Simultaneous `flush_req` (sel = 2'b11, data 0xDEADBEEF) and `req_valid` in IDLE. Expect FLUSH first: both strobes plus `flush_ack` for one cycle with data 0xDEADBEEF; the request is accepted 2 cycles later.
- `pipe_kill` in the same cycle as `asi_ready`: no `rsp_valid`; IDLE next cycle; `asi_valid` low next cycle. A kill during RESP discards the result.
- Timeout (macro on): `asi_ready` never asserted. Expect `rsp_valid` with `rsp_error = 1` and result 0 after 15 EXEC cycles. With the macro off, `busy` stays high for 100 cycles until `pipe_kill`.
- Asynchronous reset pulse mid-EXEC, between clock edges: all outputs 0 immediately; IDLE after release.
